// File: rtl/ysyx_25060173_wb_pkg.sv
// Shared defaults and types for the write-back arbiter and its round-robin core.
package ysyx_25060173_wb_pkg;

    localparam int unsigned WB_NUM_REQ    = 3;
    localparam int unsigned WB_ADDR_WIDTH = 5;
    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_CNT_WIDTH  = 2;

    // Wide enough for the largest supported requester count (8).
    localparam int unsigned REQ_IDX_W = 3;

    typedef logic [REQ_IDX_W-1:0]    req_idx_t;
    typedef logic [WB_CNT_WIDTH-1:0] wb_cnt_t;

    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned ofs,
                                            input int unsigned n);
        int unsigned s;
        s = base + ofs;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/ysyx_25060173_rr_arbiter.sv
// Generic NUM_REQ-way round-robin grant: the first valid requester at or after ptr wins.
module ysyx_25060173_rr_arbiter
    import ysyx_25060173_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = WB_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] valid,
    input  req_idx_t           ptr,
    output logic [NUM_REQ-1:0] grant,
    output req_idx_t           grant_idx,
    output logic               grant_any
);

    int unsigned          cand;
    logic [NUM_REQ-1:0]   valid_sh;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        valid_sh  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = rr_wrap(32'(ptr), k, NUM_REQ);
            valid_sh = valid >> cand;
            if (!grant_any && valid_sh[0]) begin
                grant     = NUM_REQ'(1) << cand;
                grant_idx = req_idx_t'(cand);
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_25060173_wb_arbiter.sv
// Register-file write-back arbiter with optional pending-write scoreboard.
// Scoreboard is built only when YSYX_25060173_WB_SCOREBOARD_EN is defined.
module ysyx_25060173_wb_arbiter
    import ysyx_25060173_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = WB_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = WB_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          wb_stall,
    output logic                          rf_we,
    output logic [ADDR_WIDTH-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [ADDR_WIDTH-1:0]         alloc_addr,
    input  logic [ADDR_WIDTH-1:0]         chk_addr1,
    output logic                          chk_busy1,
    input  logic [ADDR_WIDTH-1:0]         chk_addr2,
    output logic                          chk_busy2
);

    logic [NUM_REQ-1:0]    grant;
    req_idx_t              grant_idx;
    logic                  grant_any;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    req_idx_t              rr_ptr_q,   rr_ptr_d;
    logic                  rf_we_q,    rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    ysyx_25060173_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .valid    (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_idx(grant_idx),
        .grant_any(grant_any)
    );

    always_comb begin
        req_ready  = wb_stall ? '0 : grant;
        hs         = grant_any && !wb_stall;
        sel_addr   = ADDR_WIDTH'(req_addr >> (32'(grant_idx) * ADDR_WIDTH));
        sel_data   = DATA_WIDTH'(req_data >> (32'(grant_idx) * DATA_WIDTH));
        rr_ptr_d   = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + req_idx_t'(1);
        end
        // x0 writes still complete the handshake but never reach the port.
        rf_we_d    = hs && (sel_addr != '0);
        rf_waddr_d = rf_we_d ? sel_addr : rf_waddr_q;
        rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef YSYX_25060173_WB_SCOREBOARD_EN
    localparam int unsigned NREG = 2 ** ADDR_WIDTH;

    logic [CNT_WIDTH-1:0] cnt_q [NREG];
    logic [CNT_WIDTH-1:0] cnt_d [NREG];
    logic                 do_inc;

    always_comb begin
        // A full counter still accepts when the same register retires this cycle.
        alloc_ready = (alloc_addr == '0) || (cnt_q[alloc_addr] != '1) ||
                      (rf_we_q && (rf_waddr_q == alloc_addr));
        do_inc      = alloc_valid && alloc_ready && (alloc_addr != '0);
        chk_busy1   = (chk_addr1 != '0) && (cnt_q[chk_addr1] != '0);
        chk_busy2   = (chk_addr2 != '0) && (cnt_q[chk_addr2] != '0);
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (do_inc && (alloc_addr == ADDR_WIDTH'(r))) begin
                if (!(rf_we_q && (rf_waddr_q == ADDR_WIDTH'(r)))) cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (rf_we_q && (rf_waddr_q == ADDR_WIDTH'(r)) && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    dec_from_zero: assert property (@(posedge clk) disable iff (rst)
        !(rf_we_q && (cnt_q[rf_waddr_q] == '0)));
`else
    logic unused_sb_inputs;

    assign unused_sb_inputs = ^{alloc_valid, alloc_addr, chk_addr1, chk_addr2};
    assign alloc_ready      = 1'b1;
    assign chk_busy1        = 1'b0;
    assign chk_busy2        = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25060173_wb_arbiter.sv
// Scoreboard bench for ysyx_25060173_wb_arbiter; scoreboard checks need YSYX_25060173_WB_SCOREBOARD_EN.
module tb_ysyx_25060173_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  valid;
    logic [4:0]  addr [3];
    logic [31:0] data [3];
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        alloc_valid, alloc_ready;
    logic [4:0]  alloc_addr, chk_addr1, chk_addr2;
    logic        chk_busy1, chk_busy2;

    typedef struct {
        int          due;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    assign req_addr = {addr[2], addr[1], addr[0]};
    assign req_data = {data[2], data[1], data[0]};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_25060173_wb_arbiter #(
        .NUM_REQ(3), .ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
        .chk_addr1(chk_addr1), .chk_busy1(chk_busy1),
        .chk_addr2(chk_addr2), .chk_busy2(chk_busy2)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Sample at the falling edge: check the grant and queue the write it must produce.
    task automatic step(input logic [2:0] er);
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(er));
        for (int i = 0; i < 3; i++)
            if (er[i] && addr[i] != 5'd0)
                exp_q.push_back('{due: cyc + 1, a: addr[i], d: data[i]});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [4:0] a);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        nxt();
        alloc_valid = 1'b0;
    endtask

    // Monitor: every register-file write must match the oldest expected one, in its cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== exp_q[0].a || rf_wdata !== exp_q[0].d) begin
                errors++;
                $display("FAIL rf_write got we=%0b a=%0d d=%0h want we=1 a=%0d d=%0h (cycle %0d)",
                         rf_we, rf_waddr, rf_wdata, exp_q[0].a, exp_q[0].d, cyc);
            end
            void'(exp_q.pop_front());
        end else if (rf_we !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL rf_write_unexpected got we=%0b a=%0d d=%0h want we=0 (cycle %0d)",
                     rf_we, rf_waddr, rf_wdata, cyc);
        end
    end

    initial begin
        rst = 1'b1; valid = '0; wb_stall = 1'b0;
        alloc_valid = 1'b0; alloc_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; data[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk_addr1 = 5'd1; chk_addr2 = 5'd2; alloc_addr = 5'd1;
        @(negedge clk);
        check("rst_we",     32'(rf_we),       32'd0);
        check("rst_waddr",  32'(rf_waddr),    32'd0);
        check("rst_wdata",  rf_wdata,         32'd0);
        check("rst_aready", 32'(alloc_ready), 32'd1);
        check("rst_busy1",  32'(chk_busy1),   32'd0);
        check("rst_busy2",  32'(chk_busy2),   32'd0);
        nxt();

        // Reset priority: 0,1,2 back to back.
`ifdef YSYX_25060173_WB_SCOREBOARD_EN
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
`endif
        addr[0] = 5'd1; data[0] = 32'hA;
        addr[1] = 5'd2; data[1] = 32'hB;
        addr[2] = 5'd3; data[2] = 32'hC;
        valid = 3'b111; step(3'b001); nxt();
        valid = 3'b110; step(3'b010); nxt();
        valid = 3'b100; step(3'b100); nxt();
        valid = 3'b000; step(3'b000); nxt();

        // Fairness: requester 0 always valid, requester 2 joins.
`ifdef YSYX_25060173_WB_SCOREBOARD_EN
        alloc(5'd4); alloc(5'd4); alloc(5'd4); alloc(5'd7); alloc(5'd7);
`endif
        addr[0] = 5'd4; data[0] = 32'h41;
        valid = 3'b001; step(3'b001); nxt();
        data[0] = 32'h42; addr[2] = 5'd7; data[2] = 32'h71;
        valid = 3'b101; step(3'b100); nxt();
        data[2] = 32'h72; step(3'b001); nxt();
        data[0] = 32'h43; step(3'b100); nxt();
        step(3'b001); nxt();
        valid = 3'b000;

        // x0 write: handshake completes, no port write, pointer moves to 2.
`ifdef YSYX_25060173_WB_SCOREBOARD_EN
        alloc(5'd1); alloc(5'd2);
`endif
        addr[1] = 5'd0; data[1] = 32'hFFFF_FFFF;
        valid = 3'b010; step(3'b010); nxt();
        addr[0] = 5'd1; data[0] = 32'hD0; addr[2] = 5'd2; data[2] = 32'hD2;
        valid = 3'b111; step(3'b100); nxt();
        valid = 3'b001; step(3'b001); nxt();
        valid = 3'b000;

        // Stall: accepted write drains once, nothing more until stall drops.
`ifdef YSYX_25060173_WB_SCOREBOARD_EN
        alloc(5'd8); alloc(5'd9); alloc(5'd10);
`endif
        addr[0] = 5'd8;  data[0] = 32'h80;
        addr[1] = 5'd9;  data[1] = 32'h90;
        addr[2] = 5'd10; data[2] = 32'hA0;
        valid = 3'b111; step(3'b010); nxt();
        valid = 3'b101; wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(3'b000);
            if (k > 0) check("stall_we", 32'(rf_we), 32'd0);
            nxt();
        end
        wb_stall = 1'b0; step(3'b100); nxt();
        valid = 3'b001; step(3'b001); nxt();
        valid = 3'b000;

`ifdef YSYX_25060173_WB_SCOREBOARD_EN
        chk_addr1 = 5'd5; chk_addr2 = 5'd6;
        alloc_valid = 1'b1; alloc_addr = 5'd5;
        @(negedge clk); check("alloc_rdy_empty", 32'(alloc_ready), 32'd1); nxt();
        @(negedge clk); check("busy_cnt1", 32'(chk_busy1), 32'd1);
        check("busy_other", 32'(chk_busy2), 32'd0); nxt();
        alloc_valid = 1'b0; addr[0] = 5'd5; data[0] = 32'h55;
        valid = 3'b001; step(3'b001); check("busy_cnt2", 32'(chk_busy1), 32'd1); nxt();
        valid = 3'b000; alloc_valid = 1'b1;
        @(negedge clk); check("alloc_rdy_samecyc", 32'(alloc_ready), 32'd1); nxt();
        @(negedge clk); check("alloc_rdy_cnt2", 32'(alloc_ready), 32'd1); nxt();
        @(negedge clk); check("alloc_full", 32'(alloc_ready), 32'd0); nxt();
        alloc_addr = 5'd0; chk_addr2 = 5'd0;
        @(negedge clk); check("alloc_x0", 32'(alloc_ready), 32'd1);
        check("busy_x0", 32'(chk_busy2), 32'd0); nxt();
        alloc_valid = 1'b0; alloc_addr = 5'd5;
        valid = 3'b001; data[0] = 32'h56; step(3'b001); nxt();
        data[0] = 32'h57; step(3'b001); check("alloc_full_dec", 32'(alloc_ready), 32'd1); nxt();
        valid = 3'b000;
        @(negedge clk); check("busy_cnt2_after", 32'(chk_busy1), 32'd1); nxt();
        valid = 3'b001; data[0] = 32'h58; step(3'b001); check("busy_cnt1", 32'(chk_busy1), 32'd1); nxt();
        valid = 3'b000;
        @(negedge clk); check("busy_no_bypass", 32'(chk_busy1), 32'd1); nxt();
        @(negedge clk); check("busy_cleared", 32'(chk_busy1), 32'd0); nxt();
        alloc(5'd6); alloc(5'd6);
`endif

        // Asynchronous reset in the middle of a registered write.
        chk_addr1 = 5'd6; alloc_addr = 5'd6;
        addr[0] = 5'd6; data[0] = 32'h66;
        valid = 3'b001; step(3'b001); nxt();
        valid = 3'b000;
        check("pre_rst_we", 32'(rf_we), 32'd1);
        check("pre_rst_waddr", 32'(rf_waddr), 32'd6);
`ifdef YSYX_25060173_WB_SCOREBOARD_EN
        check("pre_rst_busy", 32'(chk_busy1), 32'd1);
`endif
        exp_q.delete();
        #2 rst = 1'b1;
        #1;
        check("arst_we",     32'(rf_we),       32'd0);
        check("arst_waddr",  32'(rf_waddr),    32'd0);
        check("arst_busy",   32'(chk_busy1),   32'd0);
        check("arst_aready", 32'(alloc_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) addr[i] = '0;
        valid = 3'b111; step(3'b001); nxt();
        valid = 3'b000;
        repeat (2) nxt();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_queue_drained got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
